life_sequencer: RTL and testbench

- Controller for the 16x16 Game-of-Life datapath: seed mux, next-generation logic and grid flop.
- Sequences seed load, free-running generations at a programmable rate, and single-step.
- Counts generations and halts on extinction (all-dead grid) or still life (grid unchanged after a generation).
- Sits between the top-level user controls and the grid datapath. Drives the datapath mux select, grid enable and grid clear.

---
 rtl/life_pkg.sv | 25 ++
 rtl/life_tick_gen.sv | 39 +++
 rtl/life_sequencer.sv | 151 +++++++++++++++
 tb/tb_life_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared definitions for the 16x16 Game-of-Life sequencer slice.
//   CELLS       : number of cells in the grid (row-major, bit 255 = top-left)
//   GRID_DIM    : side length of the square grid
//   grid_t      : one full grid image
//   seq_state_t : sequencer control states
// -----------------------------------------------------------------------------
package life_pkg;

    localparam int CELLS    = 256;
    localparam int GRID_DIM = 16;

    typedef logic [CELLS-1:0] grid_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        ADV,
        CHECK,
        HALT
    } seq_state_t;

endpackage

// File: rtl/life_tick_gen.sv
// -----------------------------------------------------------------------------
// life_tick_gen
// Loadable down-counter that paces free-running generations.
//   clk     : system clock
//   reset   : synchronous active-high reset, clears the count to zero
//   reload  : load the count with TICK_DIV-1
//   en      : decrement by one while the count is non-zero
//   expire  : count has reached zero
// -----------------------------------------------------------------------------
module life_tick_gen #(
    parameter int TICK_DIV = 4,
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] RELOAD_VAL = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    // Reload has priority over counting; the count parks at zero once
    // expired so a held enable cannot wrap it around.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (reload) begin
            count <= RELOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/life_sequencer.sv
// -----------------------------------------------------------------------------
// life_sequencer
// Controller for the Game-of-Life datapath (seed mux, next-gen logic, grid flop).
//   clk       : system clock
//   reset     : synchronous active-high reset
//   load      : pulse, load the seed into the grid
//   run       : level, free-run generations every TICK_DIV+2 cycles
//   step      : pulse, advance exactly one generation
//   grid_q    : current grid from the datapath flop
//   mux_sel   : datapath mux, 0 = seed, 1 = next generation
//   grid_en   : grid flop enable
//   grid_clr  : synchronous clear of the grid flop (reset only)
//   gen_count : generations since the last load, saturating
//   extinct   : sticky, grid became all dead
//   stable    : sticky, a generation left the grid unchanged
//   busy      : sequencer is in LOAD, RUN, ADV or CHECK
// -----------------------------------------------------------------------------
module life_sequencer
    import life_pkg::*;
#(
    parameter int CELLS    = life_pkg::CELLS,
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic             step,
    input  logic [CELLS-1:0] grid_q,
    output logic             mux_sel,
    output logic             grid_en,
    output logic             grid_clr,
    output logic [GEN_W-1:0] gen_count,
    output logic             extinct,
    output logic             stable,
    output logic             busy
);

    seq_state_t       state;
    logic             ret_run;
    logic [CELLS-1:0] prev_grid;

    logic tick_reload;
    logic tick_en;
    logic tick_expire;

    // Every path into RUN passes through IDLE or CHECK, so reloading the
    // tick counter in those states guarantees a fresh TICK_DIV-1 on entry.
    assign tick_reload = (state == IDLE) || (state == CHECK);
    assign tick_en     = (state == RUN) && run && !load;

    life_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .reload (tick_reload),
        .en     (tick_en),
        .expire (tick_expire)
    );

    // Sequencer FSM. Datapath controls are registered, so they are set on
    // the edge that enters LOAD or ADV and fall back to defaults elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mux_sel   <= 1'b1;
            grid_en   <= 1'b0;
            grid_clr  <= 1'b1;
            gen_count <= '0;
            extinct   <= 1'b0;
            stable    <= 1'b0;
            prev_grid <= '0;
            ret_run   <= 1'b0;
        end else begin
            grid_clr <= 1'b0;
            grid_en  <= 1'b0;
            mux_sel  <= 1'b1;
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= LOAD;
                        grid_en <= 1'b1;
                        mux_sel <= 1'b0;
                    end else if (step) begin
                        state   <= ADV;
                        ret_run <= 1'b0;
                        grid_en <= 1'b1;
                    end else if (run) begin
                        state <= RUN;
                    end
                end
                LOAD: begin
                    gen_count <= '0;
                    extinct   <= 1'b0;
                    stable    <= 1'b0;
                    state     <= IDLE;
                end
                RUN: begin
                    if (load) begin
                        state   <= LOAD;
                        grid_en <= 1'b1;
                        mux_sel <= 1'b0;
                    end else if (!run) begin
                        state <= IDLE;
                    end else if (tick_expire) begin
                        state   <= ADV;
                        ret_run <= 1'b1;
                        grid_en <= 1'b1;
                    end
                end
                ADV: begin
                    prev_grid <= grid_q;
                    if (gen_count != '1) begin
                        gen_count <= gen_count + GEN_W'(1);
                    end
                    state <= CHECK;
                end
                CHECK: begin
                    // Extinction wins over still life when the grid is empty.
                    if (grid_q == '0) begin
                        extinct <= 1'b1;
                        state   <= HALT;
                    end else if (grid_q == prev_grid) begin
                        stable <= 1'b1;
                        state  <= HALT;
                    end else if (ret_run) begin
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (load) begin
                        state   <= LOAD;
                        grid_en <= 1'b1;
                        mux_sel <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == LOAD) || (state == RUN) ||
                  (state == ADV)  || (state == CHECK);

endmodule

// File: tb/tb_life_sequencer.sv
// -----------------------------------------------------------------------------
// tb_life_sequencer
// Drives two sequencers (16-bit and 3-bit generation counters) with shared
// controls, each wrapped in its own seed mux / next-generation / grid flop
// datapath, and checks them every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_life_sequencer;
    import life_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 16;
    localparam int SMALL_W  = 3;

    localparam grid_t BLINKER_H = 256'h0000_7000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
    localparam grid_t BLINKER_V = 256'h2000_2000_2000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
    localparam grid_t SINGLE    = 256'h0000_1000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
    localparam grid_t BLOCK     = 256'h0000_6000_6000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset;
    logic load;
    logic step;
    logic run;
    grid_t seed;

    grid_t             grid_a;
    logic              mux_a, en_a, clr_a, ext_a, stab_a, busy_a;
    logic [GEN_W-1:0]  gen_a;

    grid_t             grid_b;
    logic              mux_b, en_b, clr_b, ext_b, stab_b, busy_b;
    logic [SMALL_W-1:0] gen_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_sequencer #(.CELLS(CELLS), .TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut_a (
        .clk(clk), .reset(reset), .load(load), .run(run), .step(step),
        .grid_q(grid_a), .mux_sel(mux_a), .grid_en(en_a), .grid_clr(clr_a),
        .gen_count(gen_a), .extinct(ext_a), .stable(stab_a), .busy(busy_a)
    );

    life_sequencer #(.CELLS(CELLS), .TICK_DIV(TICK_DIV), .GEN_W(SMALL_W)) dut_b (
        .clk(clk), .reset(reset), .load(load), .run(run), .step(step),
        .grid_q(grid_b), .mux_sel(mux_b), .grid_en(en_b), .grid_clr(clr_b),
        .gen_count(gen_b), .extinct(ext_b), .stable(stab_b), .busy(busy_b)
    );

    // Conway's rule on a bounded 16x16 field; cells beyond the edge are dead.
    function automatic grid_t life_next(input grid_t g);
        grid_t n;
        int cnt;
        int rr;
        int cc;
        n = '0;
        for (int r = 0; r < GRID_DIM; r++) begin
            for (int c = 0; c < GRID_DIM; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < GRID_DIM &&
                            cc >= 0 && cc < GRID_DIM) begin
                            cnt += int'(g[255 - (rr * GRID_DIM + cc)]);
                        end
                    end
                end
                if (g[255 - (r * GRID_DIM + c)])
                    n[255 - (r * GRID_DIM + c)] = (cnt == 2 || cnt == 3);
                else
                    n[255 - (r * GRID_DIM + c)] = (cnt == 3);
            end
        end
        return n;
    endfunction

    // Grid datapaths around each sequencer: reset or grid_clr empties the
    // flop, otherwise an enabled edge captures seed or next generation.
    always @(posedge clk) begin
        if (reset || clr_a)
            grid_a <= '0;
        else if (en_a)
            grid_a <= mux_a ? life_next(grid_a) : seed;
        if (reset || clr_b)
            grid_b <= '0;
        else if (en_b)
            grid_b <= mux_b ? life_next(grid_b) : seed;
    end

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic rn);
        @(negedge clk);
        load = ld;
        step = st;
        run  = rn;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: tracks which activity the sequencer is engaged in,
    // how many run cycles remain before the next generation, and what the
    // grid and flags must be.
    // ------------------------------------------------------------------
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_ADV   = 3;
    localparam int M_CHECK = 4;
    localparam int M_HALT  = 5;

    int    m_phase = M_IDLE;
    int    m_wait  = 0;
    bit    m_back_to_run = 0;
    int    m_gen   = 0;
    bit    m_ext   = 0;
    bit    m_stab  = 0;
    bit    m_clr   = 0;
    grid_t m_grid  = '0;
    grid_t m_prev  = '0;
    bit    checking = 0;

    always @(posedge clk) begin : model
        grid_t old_grid;
        bit    old_clr;
        old_grid = m_grid;
        old_clr  = m_clr;
        if (reset) begin
            m_phase = M_IDLE;
            m_gen   = 0;
            m_ext   = 0;
            m_stab  = 0;
            m_prev  = '0;
            m_grid  = '0;
            m_clr   = 1;
            m_wait  = 0;
            m_back_to_run = 0;
            checking = 1;
        end else begin
            m_clr = 0;
            if (old_clr)
                m_grid = '0;
            else if (m_phase == M_LOAD)
                m_grid = seed;
            else if (m_phase == M_ADV)
                m_grid = life_next(old_grid);
            case (m_phase)
                M_IDLE: begin
                    if (load) m_phase = M_LOAD;
                    else if (step) begin m_phase = M_ADV; m_back_to_run = 0; end
                    else if (run) begin m_phase = M_RUN; m_wait = TICK_DIV; end
                end
                M_LOAD: begin
                    m_gen = 0; m_ext = 0; m_stab = 0;
                    m_phase = M_IDLE;
                end
                M_RUN: begin
                    if (load) m_phase = M_LOAD;
                    else if (!run) m_phase = M_IDLE;
                    else begin
                        m_wait--;
                        if (m_wait == 0) begin m_phase = M_ADV; m_back_to_run = 1; end
                    end
                end
                M_ADV: begin
                    m_prev = old_grid;
                    m_gen++;
                    m_phase = M_CHECK;
                end
                M_CHECK: begin
                    if (old_grid == '0) begin m_ext = 1; m_phase = M_HALT; end
                    else if (old_grid == m_prev) begin m_stab = 1; m_phase = M_HALT; end
                    else if (m_back_to_run) begin m_phase = M_RUN; m_wait = TICK_DIV; end
                    else m_phase = M_IDLE;
                end
                default: begin
                    if (load) m_phase = M_LOAD;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of both sequencers against the model.
    always @(negedge clk) begin
        if (checking) begin
            logic exp_en;
            logic exp_mux;
            logic exp_busy;
            exp_en   = (m_phase == M_LOAD) || (m_phase == M_ADV);
            exp_mux  = (m_phase != M_LOAD);
            exp_busy = (m_phase != M_IDLE) && (m_phase != M_HALT);
            checkOutput("a_grid_en", en_a, exp_en);
            checkOutput("a_mux_sel", mux_a, exp_mux);
            checkOutput("a_grid_clr", clr_a, m_clr);
            checkOutput("a_busy", busy_a, exp_busy);
            checkOutput("a_gen_count", gen_a, (m_gen > 65535) ? 65535 : m_gen);
            checkOutput("a_extinct", ext_a, m_ext);
            checkOutput("a_stable", stab_a, m_stab);
            checkOutput("a_grid", grid_a, m_grid);
            checkOutput("b_grid_en", en_b, exp_en);
            checkOutput("b_busy", busy_b, exp_busy);
            checkOutput("b_gen_count", gen_b, (m_gen > 7) ? 7 : m_gen);
            checkOutput("b_extinct", ext_b, m_ext);
            checkOutput("b_stable", stab_b, m_stab);
            checkOutput("b_grid", grid_b, m_grid);
        end
    end

    task automatic wait_not_busy(input int budget, input string name);
        int n;
        n = 0;
        while (busy_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_timeout"}, busy_a, 1'b0);
    endtask

    // Pulse load for one cycle and return with the grid holding the seed.
    task automatic load_seed(input grid_t s);
        seed = s;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic step_once(input string name);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_not_busy(20, name);
    endtask

    function automatic grid_t random_grid();
        grid_t g;
        for (int w = 0; w < 8; w++)
            g[w*32 +: 32] = $urandom() & $urandom();
        return g;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int pulses;
        int last;
        int bad_gap;
        int r;
        int pick;
        reset = 1'b1;
        load  = 1'b0;
        step  = 1'b0;
        run   = 1'b0;
        seed  = '0;

        // The rule itself, pinned by hand-derived patterns.
        checkOutput("life_blinker_h2v", life_next(BLINKER_H), BLINKER_V);
        checkOutput("life_blinker_v2h", life_next(BLINKER_V), BLINKER_H);
        checkOutput("life_block", life_next(BLOCK), BLOCK);

        repeat (2) @(negedge clk);
        checkOutput("reset_grid_clr", clr_a, 1'b1);
        checkOutput("reset_grid_en", en_a, 1'b0);
        checkOutput("reset_mux_sel", mux_a, 1'b1);
        checkOutput("reset_busy", busy_a, 1'b0);
        checkOutput("reset_gen", gen_a, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_clr", clr_a, 1'b0);
        checkOutput("post_reset_grid", grid_a, '0);

        $display("[TB] blinker single-step");
        seed = BLINKER_H;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("load_grid_en", en_a, 1'b1);
        checkOutput("load_mux_sel", mux_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("load_grid", grid_a, BLINKER_H);
        step_once("step1");
        checkOutput("step1_grid", grid_a, BLINKER_V);
        checkOutput("step1_gen", gen_a, 1);
        step_once("step2");
        checkOutput("step2_grid", grid_a, BLINKER_H);
        checkOutput("step2_gen", gen_a, 2);
        checkOutput("step2_stable", stab_a, 1'b0);
        checkOutput("step2_extinct", ext_a, 1'b0);

        $display("[TB] single cell extinction");
        load_seed(SINGLE);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_not_busy(30, "extinct_run");
        checkOutput("extinct_flag", ext_a, 1'b1);
        checkOutput("extinct_gen", gen_a, 1);
        checkOutput("extinct_grid", grid_a, '0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, i[0], 1'b1);
        checkOutput("halt_gen_held", gen_a, 1);
        checkOutput("halt_busy", busy_a, 1'b0);

        $display("[TB] block still life");
        load_seed(BLOCK);
        checkOutput("reload_flags_clear", ext_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_not_busy(30, "stable_run");
        checkOutput("stable_flag", stab_a, 1'b1);
        checkOutput("stable_gen", gen_a, 1);
        checkOutput("stable_grid", grid_a, BLOCK);

        $display("[TB] blinker run for 40 cycles");
        load_seed(BLINKER_H);
        pulses  = 0;
        last    = -1;
        bad_gap = 0;
        for (int i = 0; i <= 40; i++) begin
            applyStimulus(1'b0, 1'b0, i < 40);
            if (en_a) begin
                if (last >= 0 && i - last != 6) bad_gap++;
                last = i;
                pulses++;
            end
        end
        checkOutput("run40_pulses", pulses, 6);
        checkOutput("run40_gap", bad_gap, 0);
        checkOutput("run40_gen", gen_a, 6);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] counter saturation");
        load_seed(BLINKER_H);
        for (int i = 0; i < 80; i++)
            applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sat_small_gen", gen_b, 7);
        checkOutput("sat_wide_gen", gen_a, 13);
        checkOutput("sat_grid", grid_b, BLINKER_V);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] load preempts run");
        load_seed(BLINKER_H);
        step_once("pre_step");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        seed = BLOCK;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("preempt_load_en", en_a, 1'b1);
        checkOutput("preempt_load_mux", mux_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("preempt_grid", grid_a, BLOCK);
        checkOutput("preempt_gen", gen_a, 0);

        $display("[TB] reset during ADV");
        load_seed(BLINKER_H);
        step_once("pre_reset_step");
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        step = 1'b0;
        checkOutput("adv_seen", en_a & mux_a, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("adv_reset_grid", grid_a, '0);
        checkOutput("adv_reset_gen", gen_a, 0);
        checkOutput("adv_reset_clr", clr_a, 1'b1);
        checkOutput("adv_reset_en", en_a, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            @(negedge clk);
            reset = (r < 5);
            load  = (r >= 5 && r < 40);
            step  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if (load) begin
                pick = $urandom_range(0, 4);
                case (pick)
                    0: seed = BLINKER_H;
                    1: seed = SINGLE;
                    2: seed = BLOCK;
                    3: seed = BLINKER_V;
                    default: seed = random_grid();
                endcase
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
